// File: rtl/hall_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : hall_conditioner_if
// Description : Signal bundle between the Hall-sensor conditioner and its
//               user: raw sensor inputs and clear in, filtered levels,
//               edge pulses and period measurements out.
// Revision    : 1.0 - initial release
// ============================================================================
interface hall_conditioner_if;
    logic        sa1;
    logic        sa2;
    logic        clear;
    logic        m1;
    logic        m2;
    logic        edge1;
    logic        edge2;
    logic [31:0] period1;
    logic [31:0] period2;
    logic        valid1;
    logic        valid2;
    logic        stall1;
    logic        stall2;

    // User side: drives the raw sensors and clear, observes the results
    modport master (
        output sa1, sa2, clear,
        input  m1, m2, edge1, edge2, period1, period2,
        input  valid1, valid2, stall1, stall2
    );

    // Conditioner side
    modport slave (
        input  sa1, sa2, clear,
        output m1, m2, edge1, edge2, period1, period2,
        output valid1, valid2, stall1, stall2
    );
endinterface
`default_nettype wire

// File: rtl/hall_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : hall_conditioner
// Description : Two identical Hall-encoder channels. Each one synchronises
//               its raw input, debounces it with a stable-count filter,
//               pulses on filtered rising edges and, optionally, measures
//               the clock count between rising edges with stall detection.
//               Optional period logic: define HALL_CONDITIONER_PERIOD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_conditioner #(
    parameter int          FILTER_LEN  = 16,
    parameter logic [31:0] STALL_LIMIT = 32'd1_000_000
) (
    input logic               clk,
    input logic               reset,
    hall_conditioner_if.slave hif
);

    localparam logic [15:0] C_FILT_MAX = 16'(FILTER_LEN - 1);

    logic [1:0]  w_sa;
    logic [1:0]  w_m;
    logic [1:0]  w_edge;
    logic [1:0]  w_valid;
    logic [1:0]  w_stall;
    logic [31:0] w_period [2];

    assign w_sa[0] = hif.sa1;
    assign w_sa[1] = hif.sa2;

    assign hif.m1      = w_m[0];
    assign hif.m2      = w_m[1];
    assign hif.edge1   = w_edge[0];
    assign hif.edge2   = w_edge[1];
    assign hif.period1 = w_period[0];
    assign hif.period2 = w_period[1];
    assign hif.valid1  = w_valid[0];
    assign hif.valid2  = w_valid[1];
    assign hif.stall1  = w_stall[0];
    assign hif.stall2  = w_stall[1];

`ifndef HALL_CONDITIONER_PERIOD_EN
    // Clear and the stall threshold only matter to the period logic
    logic [32:0] w_unused_cfg;
    assign w_unused_cfg = {hif.clear, STALL_LIMIT};
`endif

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic        r_sync1;
        logic        r_sync2;
        logic [15:0] r_fcnt;
        logic        r_m;
        logic        r_edge;
        logic        w_toggle;

        // Level has disagreed long enough: accept it this cycle
        assign w_toggle = (r_sync2 != r_m) && (r_fcnt == C_FILT_MAX);

        // Two-flop synchroniser for the asynchronous sensor input
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_sa[g];
                r_sync2 <= r_sync1;
            end
        end

        // Stable-count filter: any agreeing cycle restarts the count
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_fcnt <= 16'd0;
                r_m    <= 1'b0;
            end else if (w_toggle) begin
                r_fcnt <= 16'd0;
                r_m    <= ~r_m;
            end else if (r_sync2 != r_m) begin
                r_fcnt <= r_fcnt + 16'd1;
            end else begin
                r_fcnt <= 16'd0;
            end
        end

        // One-cycle pulse coinciding with the first cycle m reads 1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_edge <= 1'b0;
            end else begin
                r_edge <= w_toggle & ~r_m;
            end
        end

        assign w_m[g]    = r_m;
        assign w_edge[g] = r_edge;

`ifdef HALL_CONDITIONER_PERIOD_EN
        localparam logic [31:0] C_STALL_M1 =
            (STALL_LIMIT == 32'd0) ? 32'd0 : STALL_LIMIT - 32'd1;

        logic [31:0] r_cnt;
        logic [31:0] r_period;
        logic        r_valid;
        logic        r_stall;
        logic        r_seen;
        logic [31:0] w_cnt_inc;

        // Saturating increment, shared by the counter and the period load
        assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

        // Period measurement; the registered edge pulse marks the rising
        // edge, so a clear during the pulse cycle overrides the load
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt    <= 32'd0;
                r_period <= 32'd0;
                r_valid  <= 1'b0;
                r_stall  <= 1'b0;
                r_seen   <= 1'b0;
            end else if (hif.clear) begin
                r_cnt    <= 32'd0;
                r_period <= 32'd0;
                r_valid  <= 1'b0;
                r_stall  <= 1'b0;
                r_seen   <= 1'b0;
            end else if (r_edge) begin
                r_cnt   <= 32'd0;
                r_stall <= 1'b0;
                r_seen  <= 1'b1;
                if (r_seen) begin
                    r_period <= w_cnt_inc;
                    r_valid  <= 1'b1;
                end
            end else begin
                r_cnt <= w_cnt_inc;
                if (r_cnt >= C_STALL_M1) begin
                    r_stall <= 1'b1;
                end
            end
        end

        assign w_period[g] = r_period;
        assign w_valid[g]  = r_valid;
        assign w_stall[g]  = r_stall;
`else
        assign w_period[g] = 32'd0;
        assign w_valid[g]  = 1'b0;
        assign w_stall[g]  = 1'b0;
`endif
    end

endmodule
`default_nettype wire
